pipeline_sequencer: RTL

Sequences the three-deep command history that feeds the instruction decoder. Its outputs drive the decoder's two-before, before and current command inputs. It accepts fetched commands, inserts bubbles on load-use hazards and missing fetches, squashes wrong-path commands on taken branches, and drains the pipe on HLT. It sits between instruction fetch and the decoder, and owns the PC advance enable.

---
 rtl/pipeline_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Keeps the three-deep command history that feeds the instruction decoder.
// Fetched commands shift in through cmd_0 -> cmd_1 -> cmd_2. A NOP bubble is
// shifted in instead when there is a load-use hazard or no valid fetch.
// A taken branch squashes wrong-path commands and is followed by a fixed
// number of flush bubbles. An accepted HLT drains until it sits in cmd_2,
// and the block then parks in HALT.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           leave IDLE or HALT and begin issuing
//   fetched_cmd     command from instruction memory
//   fetch_valid     fetched_cmd is valid this cycle
//   branch_taken    command in cmd_1 resolved as a taken branch
//   cmd_0/1/2       current, one-before and two-before command
//   pc_en           PC advances this cycle (combinational)
//   halted          HLT has reached cmd_2
//   state           IDLE=0 RUN=1 FLUSH=2 DRAIN=3 HALT=4
//   issue_count     saturating count of non-bubble commands accepted
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter logic [15:0] NOP_CMD      = 16'hBF00,
    parameter logic [3:0]  HLT_FUNC     = 4'b1111,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] fetched_cmd,
    input  logic        fetch_valid,
    input  logic        branch_taken,
    output logic [15:0] cmd_0,
    output logic [15:0] cmd_1,
    output logic [15:0] cmd_2,
    output logic        pc_en,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] issue_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Counter value loaded on a taken branch; FLUSH exits once it reaches 0.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    // HLT needs two more shifts to travel from cmd_0 to cmd_2.
    localparam logic [2:0] DRAIN_LOAD = 3'd2;

    function automatic logic is_hlt(input logic [15:0] cmd);
        return (cmd[15:14] == 2'b11) && (cmd[7:4] == HLT_FUNC);
    endfunction

    // A load in cmd_0 whose destination is read by the incoming ALU/store
    // class command must let the load complete first.
    function automatic logic load_use(input logic [15:0] ld_cmd,
                                      input logic [15:0] nxt_cmd,
                                      input logic        nxt_valid);
        logic ld_s;
        logic reader_s;
        logic match_s;
        ld_s     = (ld_cmd[15:14] == 2'b00);
        reader_s = (nxt_cmd[15:14] == 2'b11) || (nxt_cmd[15:14] == 2'b01);
        match_s  = (nxt_cmd[10:8] == ld_cmd[13:11]) ||
                   (nxt_cmd[13:11] == ld_cmd[13:11]);
        return ld_s && nxt_valid && reader_s && match_s;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cmd0_r, cmd0_s;
    logic [15:0] cmd1_r, cmd1_s;
    logic [15:0] cmd2_r, cmd2_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        halted_r, halted_s;
    logic [15:0] issue_r, issue_s;
    logic        pc_en_s;
    logic        hazard_s;

    // Next-state, next-history and PC enable decode.
    always_comb begin
        state_s  = state_r;
        cmd0_s   = cmd0_r;
        cmd1_s   = cmd1_r;
        cmd2_s   = cmd2_r;
        cnt_s    = cnt_r;
        halted_s = halted_r;
        issue_s  = issue_r;
        pc_en_s  = 1'b0;
        hazard_s = load_use(cmd0_r, fetched_cmd, fetch_valid);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (branch_taken) begin
                    // The branch itself stays in the history; the two younger
                    // wrong-path slots are squashed.
                    cmd2_s  = cmd1_r;
                    cmd1_s  = NOP_CMD;
                    cmd0_s  = NOP_CMD;
                    cnt_s   = FLUSH_LOAD;
                    state_s = ST_FLUSH;
                end else if (hazard_s || !fetch_valid) begin
                    cmd2_s = cmd1_r;
                    cmd1_s = cmd0_r;
                    cmd0_s = NOP_CMD;
                end else begin
                    cmd2_s  = cmd1_r;
                    cmd1_s  = cmd0_r;
                    cmd0_s  = fetched_cmd;
                    pc_en_s = 1'b1;
                    if (issue_r != 16'hFFFF) begin
                        issue_s = issue_r + 16'd1;
                    end else begin
                        issue_s = issue_r;
                    end
                    if (is_hlt(fetched_cmd)) begin
                        cnt_s   = DRAIN_LOAD;
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                cmd2_s = cmd1_r;
                cmd1_s = cmd0_r;
                cmd0_s = NOP_CMD;
                if (cnt_r == 3'd0) begin
                    state_s = ST_RUN;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_DRAIN: begin
                if (branch_taken) begin
                    cmd2_s  = cmd1_r;
                    cmd1_s  = NOP_CMD;
                    cmd0_s  = NOP_CMD;
                    cnt_s   = FLUSH_LOAD;
                    state_s = ST_FLUSH;
                end else begin
                    cmd2_s = cmd1_r;
                    cmd1_s = cmd0_r;
                    cmd0_s = NOP_CMD;
                    cnt_s  = cnt_r - 3'd1;
                    // Last drain shift puts HLT into cmd_2.
                    if (cnt_r <= 3'd1) begin
                        cnt_s    = 3'd0;
                        halted_s = 1'b1;
                        state_s  = ST_HALT;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    cmd0_s   = NOP_CMD;
                    cmd1_s   = NOP_CMD;
                    cmd2_s   = NOP_CMD;
                    halted_s = 1'b0;
                    state_s  = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                // Unreachable encodings recover to a clean idle pipe.
                cmd0_s   = NOP_CMD;
                cmd1_s   = NOP_CMD;
                cmd2_s   = NOP_CMD;
                cnt_s    = 3'd0;
                halted_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cmd0_r   <= NOP_CMD;
            cmd1_r   <= NOP_CMD;
            cmd2_r   <= NOP_CMD;
            cnt_r    <= 3'd0;
            halted_r <= 1'b0;
            issue_r  <= 16'd0;
        end else begin
            state_r  <= state_s;
            cmd0_r   <= cmd0_s;
            cmd1_r   <= cmd1_s;
            cmd2_r   <= cmd2_s;
            cnt_r    <= cnt_s;
            halted_r <= halted_s;
            issue_r  <= issue_s;
        end
    end

    assign cmd_0       = cmd0_r;
    assign cmd_1       = cmd1_r;
    assign cmd_2       = cmd2_r;
    assign pc_en       = pc_en_s;
    assign halted      = halted_r;
    assign state       = state_r;
    assign issue_count = issue_r;

endmodule
